alu_ctrl_pipe: RTL and testbench

Registered, handshaked ALU control decoder for the pipelined core, sitting between Decode and Execute. It replaces the combinational ALU decoder: it decodes RV32IM ALU, branch and load/store controls, holds them in a one-entry valid/ready output register, and stalls for a parametrised number of cycles on multi-cycle MUL/DIV operations. Adds SRA/SLTU/XOR/unsigned-branch encodings, half-word and unsigned load typing, illegal-op flagging and flush.

---
 rtl/alu_ctrl_if.sv | 30 +++
 rtl/alu_ctrl_pipe.sv | 195 +++++++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Decode->Execute handshake bundle for the registered ALU control decoder.
// The master side is Decode (and flush control); the slave side is alu_ctrl_pipe.
interface alu_ctrl_if #(
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ALUOp;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              op5;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ALUControl;
  logic [1:0]        DataType;
  logic              LoadUnsigned;
  logic              MdStart;
  logic              Illegal;

  modport master (
    output in_valid, ALUOp, funct3, funct7, op5, flush, out_ready,
    input  in_ready, out_valid, ALUControl, DataType, LoadUnsigned, MdStart, Illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7, op5, flush, out_ready,
    output in_ready, out_valid, ALUControl, DataType, LoadUnsigned, MdStart, Illegal
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered RV32IM ALU/branch/load-store control decoder with a one-entry
// valid/ready output register and a fixed-latency stall for MUL/DIV ops.
module alu_ctrl_pipe #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SLL  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [1:0]        dtype_q;
  logic              lu_q;
  logic              md_start_q;
  logic              ill_q;

  logic [4:0]        code_d;
  logic [1:0]        dtype_d;
  logic              lu_d;
  logic              ill_d;
  logic              md_d;
  logic [CNT_W-1:0]  start_cnt;
  logic              in_ready;
  logic              accept;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    code_d  = OP_ADD;
    dtype_d = 2'b00;
    lu_d    = 1'b0;
    ill_d   = 1'b0;
    md_d    = 1'b0;
    case (bus.ALUOp)
      2'b00: begin
        lu_d = bus.funct3[2];
        case (bus.funct3[1:0])
          2'b00:   dtype_d = 2'b01;
          2'b01:   dtype_d = 2'b10;
          2'b10:   dtype_d = 2'b00;
          default: ill_d   = 1'b1;
        endcase
      end
      2'b01: begin
        case (bus.funct3)
          3'b000, 3'b001: code_d = OP_SUB;
          3'b100, 3'b101: code_d = OP_SLT;
          3'b110, 3'b111: code_d = OP_SLTU;
          default:        ill_d  = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.op5) begin
          if (bus.funct7 == F7_MEXT) begin
            code_d = {2'b10, bus.funct3};
            md_d   = 1'b1;
          end else if (bus.funct7 == F7_ALT) begin
            if (bus.funct3 == 3'b000)      code_d = OP_SUB;
            else if (bus.funct3 == 3'b101) code_d = OP_SRA;
            else                           ill_d  = 1'b1;
          end else if (bus.funct7 == F7_BASE) begin
            code_d = base_op(bus.funct3);
          end else begin
            ill_d = 1'b1;
          end
        end else begin
          // Immediate forms: funct7 is immediate data except for the shifts.
          case (bus.funct3)
            3'b001: begin
              if (bus.funct7 == F7_BASE) code_d = OP_SLL;
              else                       ill_d  = 1'b1;
            end
            3'b101: begin
              if (bus.funct7 == F7_BASE)     code_d = OP_SRL;
              else if (bus.funct7 == F7_ALT) code_d = OP_SRA;
              else                           ill_d  = 1'b1;
            end
            default: code_d = base_op(bus.funct3);
          endcase
        end
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      code_d  = OP_ADD;
      dtype_d = 2'b00;
      lu_d    = 1'b0;
      md_d    = 1'b0;
    end
  end

  assign start_cnt = bus.funct3[2] ? DIV_CNT : MUL_CNT;
  assign in_ready  = !bus.flush && (state_q == IDLE || (state_q == FULL && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      dtype_q     <= 2'b00;
      lu_q        <= 1'b0;
      md_start_q  <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      if (bus.flush) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
      end else if (accept) begin
        ctrl_q     <= CTRL_W'(code_d);
        dtype_q    <= dtype_d;
        lu_q       <= lu_d;
        ill_q      <= ill_d;
        md_start_q <= md_d;
        // A latency of 1 needs no countdown and completes like a base op.
        if (md_d && start_cnt != '0) begin
          state_q     <= WAIT;
          cnt_q       <= start_cnt;
          out_valid_q <= 1'b0;
        end else begin
          state_q     <= FULL;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          WAIT: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= FULL;
              out_valid_q <= 1'b1;
            end
          end
          FULL: begin
            if (bus.out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.ALUControl   = ctrl_q;
  assign bus.DataType     = dtype_q;
  assign bus.LoadUnsigned = lu_q;
  assign bus.MdStart      = md_start_q;
  assign bus.Illegal      = ill_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe (MUL_LAT=2, DIV_LAT=4): stimulus pushes
// expected outputs with their due cycle; a negedge monitor pops and compares.
module tb_alu_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  typedef struct {
    logic [4:0] ctrl;
    logic [1:0] dt;
    logic       lu;
    logic       ill;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   seen = 1'b0;

  alu_ctrl_if #(.CTRL_W(5)) bus ();

  alu_ctrl_pipe #(.CTRL_W(5), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    else
      passes++;
  endtask

  // Present one op and hold it until accepted; optionally queue its expected output.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic o5, input logic [4:0] ctrl, input logic [1:0] dt,
                       input logic lu, input logic ill, input int lat, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALUOp    = op;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.op5      = o5;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
    end else if (push) begin
      e.ctrl = ctrl; e.dt = dt; e.lu = lu; e.ill = ill; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_queue", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: got out_valid=1 ALUControl=%0d, required no output", bus.ALUControl);
      end else begin
        if (!seen) begin
          chk("latency_cycle", cyc, sb[0].cyc);
          seen = 1'b1;
        end
        if (bus.out_ready) begin
          mon_e = sb.pop_front();
          seen  = 1'b0;
          chk("ALUControl",   bus.ALUControl,   mon_e.ctrl);
          chk("DataType",     bus.DataType,     mon_e.dt);
          chk("LoadUnsigned", bus.LoadUnsigned, mon_e.lu);
          chk("Illegal",      bus.Illegal,      mon_e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.funct3 = 3'b000; bus.funct7 = 7'b0;
    bus.op5 = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  bus.out_valid,    0);
    chk("rst_ALUControl", bus.ALUControl,   0);
    chk("rst_DataType",   bus.DataType,     0);
    chk("rst_LoadUns",    bus.LoadUnsigned, 0);
    chk("rst_MdStart",    bus.MdStart,      0);
    chk("rst_Illegal",    bus.Illegal,      0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Base decodes issued back to back: each due one cycle after acceptance.
    issue(2'b10, 3'b101, 7'b0100000, 1'b1, 5'd7,  2'b00, 1'b0, 1'b0, 1, 1'b1); // sra
    issue(2'b00, 3'b101, 7'b0000000, 1'b0, 5'd0,  2'b10, 1'b1, 1'b0, 1, 1'b1); // lhu
    issue(2'b00, 3'b011, 7'b0000000, 1'b0, 5'd0,  2'b00, 1'b0, 1'b1, 1, 1'b1); // bad size
    issue(2'b00, 3'b000, 7'b0000000, 1'b0, 5'd0,  2'b01, 1'b0, 1'b0, 1, 1'b1); // lb
    issue(2'b01, 3'b110, 7'b0000000, 1'b0, 5'd10, 2'b00, 1'b0, 1'b0, 1, 1'b1); // bltu
    issue(2'b01, 3'b101, 7'b0000000, 1'b0, 5'd5,  2'b00, 1'b0, 1'b0, 1, 1'b1); // bge
    issue(2'b01, 3'b010, 7'b0000000, 1'b0, 5'd0,  2'b00, 1'b0, 1'b1, 1, 1'b1); // bad branch
    issue(2'b10, 3'b000, 7'b0100000, 1'b0, 5'd0,  2'b00, 1'b0, 1'b0, 1, 1'b1); // addi
    issue(2'b11, 3'b000, 7'b0000000, 1'b1, 5'd0,  2'b00, 1'b0, 1'b1, 1, 1'b1); // reserved
    issue(2'b10, 3'b100, 7'b0000000, 1'b1, 5'd9,  2'b00, 1'b0, 1'b0, 1, 1'b1); // xor
    issue(2'b10, 3'b011, 7'b0000000, 1'b1, 5'd10, 2'b00, 1'b0, 1'b0, 1, 1'b1); // sltu
    issue(2'b10, 3'b111, 7'b0000000, 1'b1, 5'd2,  2'b00, 1'b0, 1'b0, 1, 1'b1); // and
    issue(2'b10, 3'b001, 7'b0100000, 1'b1, 5'd0,  2'b00, 1'b0, 1'b1, 1, 1'b1); // bad alt
    issue(2'b10, 3'b101, 7'b0100000, 1'b0, 5'd7,  2'b00, 1'b0, 1'b0, 1, 1'b1); // srai
    issue(2'b10, 3'b001, 7'b0000001, 1'b0, 5'd0,  2'b00, 1'b0, 1'b1, 1, 1'b1); // bad slli
    issue(2'b10, 3'b010, 7'b1111111, 1'b0, 5'd5,  2'b00, 1'b0, 1'b0, 1, 1'b1); // slti
    @(negedge clk);
    chk("base_no_MdStart", bus.MdStart, 0);
    drain();

    // DIV: pulse on +1, in_ready low on +1..+3, result on +4.
    @(posedge clk); #1;
    issue(2'b10, 3'b100, 7'b0000001, 1'b1, 5'd20, 2'b00, 1'b0, 1'b0, 4, 1'b1);
    @(negedge clk);
    chk("div_MdStart_p1",  bus.MdStart,  1);
    chk("div_in_ready_p1", bus.in_ready, 0);
    @(negedge clk);
    chk("div_MdStart_p2",  bus.MdStart,  0);
    chk("div_in_ready_p2", bus.in_ready, 0);
    @(negedge clk);
    chk("div_in_ready_p3", bus.in_ready, 0);
    drain();

    // MUL and REMU through the same path.
    @(posedge clk); #1;
    issue(2'b10, 3'b000, 7'b0000001, 1'b1, 5'd16, 2'b00, 1'b0, 1'b0, 2, 1'b1);
    @(negedge clk);
    chk("mul_MdStart", bus.MdStart, 1);
    issue(2'b10, 3'b111, 7'b0000001, 1'b1, 5'd23, 2'b00, 1'b0, 1'b0, 4, 1'b1);
    drain();

    // Output held under backpressure, then back-to-back accept on release.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(2'b10, 3'b000, 7'b0000000, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 1, 1'b1);
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct3 = 3'b000;
    bus.funct7 = 7'b0100000; bus.op5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid",  bus.out_valid,  1);
      chk("stall_ALUControl", bus.ALUControl, 0);
      chk("stall_in_ready",   bus.in_ready,   0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(2'b10, 3'b000, 7'b0100000, 1'b1, 5'd1, 2'b00, 1'b0, 1'b0, 1, 1'b1);
    drain();

    // Flush two cycles into a DIV: nothing emerges.
    @(posedge clk); #1;
    issue(2'b10, 3'b101, 7'b0000001, 1'b1, 5'd21, 2'b00, 1'b0, 1'b0, 4, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready_after", bus.in_ready, 1);
    chk("flush_MdStart",        bus.MdStart,  0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_out_valid", bus.out_valid, 0);
    end

    // Asynchronous reset mid-WAIT.
    @(posedge clk); #1;
    issue(2'b10, 3'b110, 7'b0000001, 1'b1, 5'd22, 2'b00, 1'b0, 1'b0, 4, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_MdStart",   bus.MdStart,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_out_valid", bus.out_valid, 0);
    end
    chk("arst_in_ready", bus.in_ready, 1);

    // Decoder still functional after the abort.
    @(posedge clk); #1;
    issue(2'b10, 3'b110, 7'b0000000, 1'b1, 5'd3, 2'b00, 1'b0, 1'b0, 1, 1'b1); // or
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
